// File: rtl/console_stream_arbiter_if.sv
// Console arbiter bundle: per-core valid/ready event channels, shared console strobes and
// lock status. The arbiter takes the slave side; cores and the console sink take the master side.
interface console_stream_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_kind;
    logic [32*NUM_REQ-1:0] req_data;

    logic        out_byte_en;
    logic [7:0]  out_byte;
    logic        out_matrix_en;
    logic [31:0] out_matrix;
    logic        out_matrix_end_row;
    logic        out_matrix_end;
    logic [2:0]  grant_id;
    logic        busy;
    logic [15:0] timeout_count;

    modport master (
        output req_valid, req_kind, req_data,
        input  req_ready, out_byte_en, out_byte, out_matrix_en, out_matrix,
        input  out_matrix_end_row, out_matrix_end, grant_id, busy, timeout_count
    );

    modport slave (
        input  req_valid, req_kind, req_data,
        output req_ready, out_byte_en, out_byte, out_matrix_en, out_matrix,
        output out_matrix_end_row, out_matrix_end, grant_id, busy, timeout_count
    );
endinterface

// File: rtl/console_stream_arbiter.sv
// Round-robin console arbiter with a line lock: an owner keeps the port until a newline,
// end_row, end_matrix or idle timeout. Optional "C<n>:" prefix per lock via ARB_CORE_TAG_EN.
module console_stream_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input logic                     clk,
    input logic                     resetn,
    console_stream_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [1:0] StIdle   = 2'd0;
`ifdef ARB_CORE_TAG_EN
    localparam logic [1:0] StTag    = 2'd1;
`endif
    localparam logic [1:0] StLocked = 2'd2;

    localparam logic [1:0] KindByte   = 2'd0;
    localparam logic [1:0] KindMatrix = 2'd1;
    localparam logic [1:0] KindEndRow = 2'd2;
    localparam logic [1:0] KindEndMat = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      rr_q, rr_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic [15:0]     tmo_q, tmo_d;
    logic            byte_en_q, byte_en_d;
    logic [7:0]      byte_q, byte_d;
    logic            mat_en_q, mat_en_d;
    logic [31:0]     mat_q, mat_d;
    logic            end_row_q, end_row_d;
    logic            end_mat_q, end_mat_d;
`ifdef ARB_CORE_TAG_EN
    logic [1:0]      tag_cnt_q, tag_cnt_d;
`endif

    logic            own_valid;
    logic [1:0]      own_kind;
    logic [31:0]     own_data;
    logic            sel_found;
    logic [2:0]      sel_idx;
    logic [2:0]      rr_next;
    logic            do_release;
    logic            term;
    int              best_off;
    int              off;

    // Owner channel mux; loop over constant indices keeps every select width-exact.
    always_comb begin
        own_valid = 1'b0;
        own_kind  = 2'd0;
        own_data  = 32'd0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == i[2:0]) begin
                own_valid = bus.req_valid[i];
                own_kind  = bus.req_kind[2*i +: 2];
                own_data  = bus.req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_ready[i] = (state_q == StLocked) && (grant_q == i[2:0]);
        end
    end

    // Pick the valid requester with the smallest distance forward from the rr pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        best_off  = int'(NUM_REQ);
        off       = 0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            off = (j + int'(NUM_REQ) - int'(rr_q)) % int'(NUM_REQ);
            if (bus.req_valid[j] && (off < best_off)) begin
                best_off  = off;
                sel_found = 1'b1;
                sel_idx   = j[2:0];
            end
        end
    end

    assign rr_next = 3'((int'(grant_q) + 1) % int'(NUM_REQ));

    assign term = (own_kind == KindEndRow) || (own_kind == KindEndMat) ||
                  ((own_kind == KindByte) && (own_data[7:0] == 8'h0A));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        idle_cnt_d = idle_cnt_q;
        tmo_d      = tmo_q;
        byte_en_d  = 1'b0;
        byte_d     = byte_q;
        mat_en_d   = 1'b0;
        mat_d      = mat_q;
        end_row_d  = 1'b0;
        end_mat_d  = 1'b0;
        do_release = 1'b0;
`ifdef ARB_CORE_TAG_EN
        tag_cnt_d  = tag_cnt_q;
`endif

        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    grant_d    = sel_idx;
                    idle_cnt_d = '0;
`ifdef ARB_CORE_TAG_EN
                    tag_cnt_d  = 2'd0;
                    state_d    = StTag;
`else
                    state_d    = StLocked;
`endif
                end
            end
`ifdef ARB_CORE_TAG_EN
            StTag: begin
                byte_en_d = 1'b1;
                case (tag_cnt_q)
                    2'd0:    byte_d = 8'h43;
                    2'd1:    byte_d = 8'h30 + {5'd0, grant_q};
                    default: byte_d = 8'h3A;
                endcase
                tag_cnt_d = tag_cnt_q + 2'd1;
                if (tag_cnt_q == 2'd2) begin
                    state_d = StLocked;
                end
            end
`endif
            StLocked: begin
                if (own_valid) begin
                    idle_cnt_d = '0;
                    unique case (own_kind)
                        KindByte: begin
                            byte_en_d = 1'b1;
                            byte_d    = own_data[7:0];
                        end
                        KindMatrix: begin
                            mat_en_d = 1'b1;
                            mat_d    = own_data;
                        end
                        KindEndRow: end_row_d = 1'b1;
                        KindEndMat: end_mat_d = 1'b1;
                    endcase
                    do_release = term;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_d == CntW'(LOCK_TIMEOUT)) begin
                        do_release = 1'b1;
                        if (tmo_q != 16'hFFFF) begin
                            tmo_d = tmo_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_release) begin
            state_d    = StIdle;
            rr_d       = rr_next;
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            grant_q    <= 3'd0;
            rr_q       <= 3'd0;
            idle_cnt_q <= '0;
            tmo_q      <= 16'd0;
            byte_en_q  <= 1'b0;
            byte_q     <= 8'd0;
            mat_en_q   <= 1'b0;
            mat_q      <= 32'd0;
            end_row_q  <= 1'b0;
            end_mat_q  <= 1'b0;
`ifdef ARB_CORE_TAG_EN
            tag_cnt_q  <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            idle_cnt_q <= idle_cnt_d;
            tmo_q      <= tmo_d;
            byte_en_q  <= byte_en_d;
            byte_q     <= byte_d;
            mat_en_q   <= mat_en_d;
            mat_q      <= mat_d;
            end_row_q  <= end_row_d;
            end_mat_q  <= end_mat_d;
`ifdef ARB_CORE_TAG_EN
            tag_cnt_q  <= tag_cnt_d;
`endif
        end
    end

    assign bus.out_byte_en        = byte_en_q;
    assign bus.out_byte           = byte_q;
    assign bus.out_matrix_en      = mat_en_q;
    assign bus.out_matrix         = mat_q;
    assign bus.out_matrix_end_row = end_row_q;
    assign bus.out_matrix_end     = end_mat_q;
    assign bus.grant_id           = grant_q;
    assign bus.busy               = (state_q != StIdle);
    assign bus.timeout_count      = tmo_q;

endmodule

// File: tb/tb_console_stream_arbiter.sv
// Directed bench for console_stream_arbiter (default build): expected console events are queued
// at each handshake and checked, including one-cycle latency, when the strobes appear.
module tb_console_stream_arbiter;

    localparam int NReq = 4;
    localparam int Tmo  = 256;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        int          due;
    } ev_t;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;
    int   cyc;
    ev_t  exp_q[$];

    console_stream_arbiter_if #(.NUM_REQ(NReq)) bus ();

    console_stream_arbiter #(
        .NUM_REQ      (NReq),
        .LOCK_TIMEOUT (Tmo)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int core, input bit v, input logic [1:0] k,
                           input logic [31:0] d);
        bus.req_valid[core]         = v;
        bus.req_kind[2*core +: 2]   = k;
        bus.req_data[32*core +: 32] = d;
    endtask

    // Holds the event on the core's channel until accepted; leaves valid high afterwards.
    task automatic send(input int core, input logic [1:0] k, input logic [31:0] d);
        bit  done;
        ev_t e;
        done = 1'b0;
        set_req(core, 1'b1, k, d);
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (bus.req_ready[core]) begin
                done   = 1'b1;
                e.kind = k;
                e.data = (k == 2'd0) ? {24'd0, d[7:0]} : ((k == 2'd1) ? d : 32'd0);
                e.due  = cyc + 1;
                exp_q.push_back(e);
                chk("grant_id", 64'(bus.grant_id), 64'(core));
                chk("ready_onehot", 64'(bus.req_ready), 64'(1) << core);
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("ready_timeout", 64'(bus.req_ready), 64'(1) << core);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.req_ready, bus.out_byte_en, bus.out_byte, bus.out_matrix_en,
                  bus.out_matrix_end_row, bus.out_matrix_end, bus.grant_id, bus.busy,
                  bus.timeout_count}, 64'd0);
        chk({tag, "_matrix"}, 64'(bus.out_matrix), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Scoreboard side: every strobe must match the head of the queue on its due cycle.
    always @(negedge clk) begin
        int          n;
        logic [1:0]  ok;
        logic [31:0] od;
        ev_t         e;
        n  = int'(bus.out_byte_en) + int'(bus.out_matrix_en) + int'(bus.out_matrix_end_row) +
             int'(bus.out_matrix_end);
        ok = 2'd0;
        od = 32'd0;
        if (bus.out_byte_en) begin
            ok = 2'd0;
            od = {24'd0, bus.out_byte};
        end else if (bus.out_matrix_en) begin
            ok = 2'd1;
            od = bus.out_matrix;
        end else if (bus.out_matrix_end_row) begin
            ok = 2'd2;
        end else if (bus.out_matrix_end) begin
            ok = 2'd3;
        end
        if (n != 0) begin
            chk("single_strobe", 64'(n), 64'd1);
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_strobe observed=%0h/%0h expected=none", ok, od);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("event", {30'd0, ok, od}, {30'd0, e.kind, e.data});
                chk("event_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        bus.req_valid = '0;
        bus.req_kind  = '0;
        bus.req_data  = '0;
        do_reset();

        // Line from core 0; upper payload bits are junk and must be ignored.
        send(0, 2'd0, 32'hDEAD_BE48);
        send(0, 2'd0, 32'h0000_0069);
        send(0, 2'd0, 32'hFFFF_FF0A);
        set_req(0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        chk("busy_after_newline", 64'(bus.busy), 64'd0);

        // Cores 1 and 2 contend after reset: core 1 first, one idle cycle, then core 2.
        do_reset();
        set_req(2, 1'b1, 2'd0, 32'h62);
        send(1, 2'd0, 32'h61);
        send(1, 2'd0, 32'h0A);
        set_req(1, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        chk("rearb_gap_busy", 64'(bus.busy), 64'd0);
        send(2, 2'd0, 32'h62);
        send(2, 2'd0, 32'h0A);
        set_req(2, 1'b0, 2'd0, 32'd0);

        // Matrix row from core 0.
        send(0, 2'd1, 32'd5);
        send(0, 2'd1, 32'hFFFF_FFFD);
        send(0, 2'd2, 32'h0000_1234);
        set_req(0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        chk("busy_after_end_row", 64'(bus.busy), 64'd0);
        chk("matrix_holds", 64'(bus.out_matrix), 64'hFFFF_FFFD);

        // Core 3 stalls mid-line while core 0 waits; lock released after the timeout.
        send(3, 2'd0, 32'h41);
        set_req(3, 1'b0, 2'd0, 32'd0);
        set_req(0, 1'b1, 2'd0, 32'h71);
        repeat (Tmo) @(negedge clk);
        chk("busy_last_idle_cycle", {63'd0, bus.busy}, 64'd1);
        chk("timeout_before", 64'(bus.timeout_count), 64'd0);
        @(negedge clk);
        chk("busy_after_timeout", 64'(bus.busy), 64'd0);
        chk("timeout_count", 64'(bus.timeout_count), 64'd1);
        send(0, 2'd0, 32'h71);
        send(0, 2'd0, 32'h0A);
        set_req(0, 1'b0, 2'd0, 32'd0);

        // Reset while core 2 holds the lock with 'x' pending; core 0 must win afterwards.
        set_req(2, 1'b1, 2'd0, 32'h78);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 16 && !seen; t++) begin
                @(negedge clk);
                seen = bus.req_ready[2];
            end
            chk("core2_locked", 64'(bus.req_ready), 64'd4);
        end
        #1;
        set_req(0, 1'b1, 2'd0, 32'h6B);
        resetn = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send(0, 2'd0, 32'h6B);
        set_req(2, 1'b0, 2'd0, 32'd0);
        send(0, 2'd0, 32'h0A);
        set_req(0, 1'b0, 2'd0, 32'd0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
